// File: rtl/uart_pkg.sv
// ----------------------------------------------------------------------------
// uart_pkg: shared UART receiver state encoding and oversample ratio.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

   localparam int UART_OVERSAMPLE = 16;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
      PARITY = 3'd3,
      STOP   = 3'd4
   } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/uart_sync2.sv
// ----------------------------------------------------------------------------
// uart_sync2: two-flop synchroniser with a configurable reset level.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic nrst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         meta <= RESET_VAL;
         q    <= RESET_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

`default_nettype wire

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx: oversampled UART receiver with valid/ready byte output and error
// pulses. Parity support enabled by defining UART_RX_PARITY_EN.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_rx
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = UART_OVERSAMPLE,
   parameter int PARITY_ODD = 0
) (
   input  logic                 clk,
   input  logic                 nrst,
   input  logic                 rx_tick,
   input  logic                 rxd,
   output logic [DATA_BITS-1:0] rx_data,
   output logic                 rx_valid,
   input  logic                 rx_ready,
   output logic                 frame_err,
   output logic                 overrun_err,
   output logic                 parity_err
);

   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [TW-1:0] HALF_LAST = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] BIT_LAST  = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);

   logic                 rxd_s;
   rx_state_t            state, state_n;
   logic [TW-1:0]        tick_cnt, tick_n;
   logic [BW-1:0]        bit_cnt, bit_n;
   logic [DATA_BITS-1:0] shift, shift_n, data_n;
   logic                 valid_n, frame_n, overrun_n;
   logic                 at_half, at_bit, par_bad_now;

   uart_sync2 #(.RESET_VAL(1'b1)) u_sync (
      .clk  (clk),
      .nrst (nrst),
      .d    (rxd),
      .q    (rxd_s)
   );

   assign at_half = rx_tick && (tick_cnt == HALF_LAST);
   assign at_bit  = rx_tick && (tick_cnt == BIT_LAST);

`ifdef UART_RX_PARITY_EN
   logic par_bad, par_bad_n, par_err_n;
   assign par_bad_now = par_bad;
`else
   logic unused_parity_cfg;
   assign unused_parity_cfg = (PARITY_ODD != 0);
   assign par_bad_now       = 1'b0;
   assign parity_err        = 1'b0;
`endif

   always_comb begin
      state_n   = state;
      tick_n    = tick_cnt;
      bit_n     = bit_cnt;
      shift_n   = shift;
      data_n    = rx_data;
      valid_n   = rx_valid && !rx_ready;
      frame_n   = 1'b0;
      overrun_n = 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad_n = par_bad;
      par_err_n = 1'b0;
`endif
      case (state)
         IDLE: begin
            if (rx_tick && !rxd_s) begin
               state_n = START;
               tick_n  = '0;
            end
         end
         START: begin
            // Low at mid start bit confirms a real frame; otherwise it was a glitch.
            if (at_half) begin
               tick_n  = '0;
               bit_n   = '0;
               state_n = rxd_s ? IDLE : DATA;
            end else if (rx_tick) begin
               tick_n = tick_cnt + 1'b1;
            end
         end
         DATA: begin
            if (at_bit) begin
               tick_n  = '0;
               shift_n = {rxd_s, shift[DATA_BITS-1:1]};
               if (bit_cnt == DATA_LAST) begin
`ifdef UART_RX_PARITY_EN
                  state_n = PARITY;
`else
                  state_n = STOP;
`endif
               end else begin
                  bit_n = bit_cnt + 1'b1;
               end
            end else if (rx_tick) begin
               tick_n = tick_cnt + 1'b1;
            end
         end
`ifdef UART_RX_PARITY_EN
         PARITY: begin
            if (at_bit) begin
               tick_n    = '0;
               par_bad_n = rxd_s ^ (^shift) ^ (PARITY_ODD != 0);
               state_n   = STOP;
            end else if (rx_tick) begin
               tick_n = tick_cnt + 1'b1;
            end
         end
`endif
         STOP: begin
            // Back to IDLE at mid stop bit so the next start edge is never missed.
            if (at_bit) begin
               tick_n  = '0;
               state_n = IDLE;
               if (par_bad_now) begin
`ifdef UART_RX_PARITY_EN
                  par_err_n = 1'b1;
`endif
               end else if (!rxd_s) begin
                  frame_n = 1'b1;
               end else if (rx_valid && !rx_ready) begin
                  overrun_n = 1'b1;
               end else begin
                  data_n  = shift;
                  valid_n = 1'b1;
               end
            end else if (rx_tick) begin
               tick_n = tick_cnt + 1'b1;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state       <= IDLE;
         tick_cnt    <= '0;
         bit_cnt     <= '0;
         shift       <= '0;
         rx_data     <= '0;
         rx_valid    <= 1'b0;
         frame_err   <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         state       <= state_n;
         tick_cnt    <= tick_n;
         bit_cnt     <= bit_n;
         shift       <= shift_n;
         rx_data     <= data_n;
         rx_valid    <= valid_n;
         frame_err   <= frame_n;
         overrun_err <= overrun_n;
      end
   end

`ifdef UART_RX_PARITY_EN
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         par_bad    <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         par_bad    <= par_bad_n;
         parity_err <= par_err_n;
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx: directed self-checking bench for uart_rx (8 data bits, 16x).
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_rx;
   import uart_pkg::*;

   localparam int TICK_DIV = 4;
   localparam int BIT_CLKS = 16 * TICK_DIV;

   logic       clk = 1'b0;
   logic       nrst;
   logic       rx_tick = 1'b0;
   logic       rxd;
   logic       rx_ready;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overrun_err, parity_err;

   int checks = 0, errors = 0;
   int n_frame = 0, n_overrun = 0, n_parity = 0, n_bytes = 0, n_vcyc = 0;
   int s_frame, s_overrun, s_parity, s_bytes, s_vcyc;
   logic [7:0] last_byte = 8'h00;
   int tick_div_cnt = 0;

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (tick_div_cnt == TICK_DIV - 1) begin
         tick_div_cnt <= 0;
         rx_tick      <= 1'b1;
      end else begin
         tick_div_cnt <= tick_div_cnt + 1;
         rx_tick      <= 1'b0;
      end
   end

   uart_rx #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY_ODD(0)) dut (
      .clk         (clk),
      .nrst        (nrst),
      .rx_tick     (rx_tick),
      .rxd         (rxd),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_ready    (rx_ready),
      .frame_err   (frame_err),
      .overrun_err (overrun_err),
      .parity_err  (parity_err)
   );

   // Event monitor: counts pulses and records each accepted byte.
   always @(negedge clk) begin
      #1;
      if (nrst === 1'b1) begin
         if (frame_err)   n_frame++;
         if (overrun_err) n_overrun++;
         if (parity_err)  n_parity++;
         if (rx_valid)    n_vcyc++;
         if (rx_valid && rx_ready) begin
            n_bytes++;
            last_byte = rx_data;
         end
      end
   end

   task automatic wait_clks(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic snap();
      s_frame = n_frame; s_overrun = n_overrun; s_parity = n_parity;
      s_bytes = n_bytes; s_vcyc = n_vcyc;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                             input logic use_par, input logic par_bit);
      @(negedge clk);
      rxd = 1'b0;
      wait_clks(BIT_CLKS);
      for (int i = 0; i < 8; i++) begin
         rxd = b[i];
         wait_clks(BIT_CLKS);
      end
      if (use_par) begin
         rxd = par_bit;
         wait_clks(BIT_CLKS);
      end
      rxd = stop_bit;
      wait_clks(BIT_CLKS);
      rxd = 1'b1;
   endtask

   task automatic test_reset();
      nrst = 1'b0; rxd = 1'b1; rx_ready = 1'b0;
      wait_clks(5);
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", rx_valid); end
      checks++; if ({frame_err, overrun_err, parity_err} !== 3'b000) begin errors++; $display("FAIL reset_errs: got %b expected 000", {frame_err, overrun_err, parity_err}); end
      checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL reset_state: got %0d expected %0d", dut.state, IDLE); end
      nrst = 1'b1;
      wait_clks(20);
   endtask

   task automatic test_basic();
      snap(); rx_ready = 1'b1;
      send_frame(8'hA5, 1'b1, 1'b0, 1'b0);
      wait_clks(100);
      checks++; if (n_bytes - s_bytes !== 1) begin errors++; $display("FAIL basic_count: got %0d expected 1", n_bytes - s_bytes); end
      checks++; if (last_byte !== 8'hA5) begin errors++; $display("FAIL basic_data: got %h expected a5", last_byte); end
      checks++; if (n_vcyc - s_vcyc !== 1) begin errors++; $display("FAIL basic_valid_cycles: got %0d expected 1", n_vcyc - s_vcyc); end
      checks++; if (n_frame + n_overrun + n_parity - s_frame - s_overrun - s_parity !== 0) begin errors++; $display("FAIL basic_errs: got %0d expected 0", n_frame + n_overrun + n_parity - s_frame - s_overrun - s_parity); end
   endtask

   task automatic test_back_to_back();
      snap(); rx_ready = 1'b0;
      send_frame(8'h3C, 1'b1, 1'b0, 1'b0);
      send_frame(8'h5A, 1'b1, 1'b0, 1'b0);
      wait_clks(100);
      checks++; if (rx_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid_held: got %b expected 1", rx_valid); end
      checks++; if (rx_data !== 8'h3C) begin errors++; $display("FAIL b2b_data_kept: got %h expected 3c", rx_data); end
      checks++; if (n_overrun - s_overrun !== 1) begin errors++; $display("FAIL b2b_overrun: got %0d expected 1", n_overrun - s_overrun); end
      checks++; if (n_frame - s_frame !== 0) begin errors++; $display("FAIL b2b_frame: got %0d expected 0", n_frame - s_frame); end
      rx_ready = 1'b1;
      wait_clks(2);
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL b2b_valid_drop: got %b expected 0", rx_valid); end
      checks++; if (n_bytes - s_bytes !== 1) begin errors++; $display("FAIL b2b_count: got %0d expected 1", n_bytes - s_bytes); end
      checks++; if (last_byte !== 8'h3C) begin errors++; $display("FAIL b2b_accepted: got %h expected 3c", last_byte); end
   endtask

   task automatic test_frame_err();
      snap(); rx_ready = 1'b1;
      send_frame(8'h00, 1'b0, 1'b0, 1'b0);
      wait_clks(200);
      checks++; if (n_frame - s_frame !== 1) begin errors++; $display("FAIL ferr_pulse: got %0d expected 1", n_frame - s_frame); end
      checks++; if (n_vcyc - s_vcyc !== 0) begin errors++; $display("FAIL ferr_valid: got %0d expected 0", n_vcyc - s_vcyc); end
      checks++; if (n_overrun - s_overrun !== 0) begin errors++; $display("FAIL ferr_overrun: got %0d expected 0", n_overrun - s_overrun); end
      snap();
      send_frame(8'h81, 1'b1, 1'b0, 1'b0);
      wait_clks(100);
      checks++; if (n_bytes - s_bytes !== 1) begin errors++; $display("FAIL ferr_next_count: got %0d expected 1", n_bytes - s_bytes); end
      checks++; if (last_byte !== 8'h81) begin errors++; $display("FAIL ferr_next_data: got %h expected 81", last_byte); end
      checks++; if (n_frame - s_frame !== 0) begin errors++; $display("FAIL ferr_next_frame: got %0d expected 0", n_frame - s_frame); end
   endtask

   task automatic test_glitch();
      snap();
      @(negedge clk);
      rxd = 1'b0;
      wait_clks(4 * TICK_DIV);
      rxd = 1'b1;
      wait_clks(200);
      checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL glitch_state: got %0d expected %0d", dut.state, IDLE); end
      checks++; if (n_vcyc - s_vcyc !== 0) begin errors++; $display("FAIL glitch_valid: got %0d expected 0", n_vcyc - s_vcyc); end
      checks++; if (n_frame + n_overrun + n_parity - s_frame - s_overrun - s_parity !== 0) begin errors++; $display("FAIL glitch_errs: got %0d expected 0", n_frame + n_overrun + n_parity - s_frame - s_overrun - s_parity); end
   endtask

   task automatic test_reset_mid();
      rx_ready = 1'b1;
      @(negedge clk);
      rxd = 1'b0;
      wait_clks(BIT_CLKS);
      rxd = 1'b1;
      wait_clks(3 * BIT_CLKS + 20);
      nrst = 1'b0;
      wait_clks(3);
      checks++; if (rx_data !== 8'h00) begin errors++; $display("FAIL rstmid_data: got %h expected 00", rx_data); end
      checks++; if (rx_valid !== 1'b0) begin errors++; $display("FAIL rstmid_valid: got %b expected 0", rx_valid); end
      checks++; if ({frame_err, overrun_err, parity_err} !== 3'b000) begin errors++; $display("FAIL rstmid_errs: got %b expected 000", {frame_err, overrun_err, parity_err}); end
      checks++; if (dut.state !== IDLE) begin errors++; $display("FAIL rstmid_state: got %0d expected %0d", dut.state, IDLE); end
      wait_clks(5);
      nrst = 1'b1;
      wait_clks(50);
      snap();
      send_frame(8'h12, 1'b1, 1'b0, 1'b0);
      wait_clks(100);
      checks++; if (n_bytes - s_bytes !== 1) begin errors++; $display("FAIL rstmid_count: got %0d expected 1", n_bytes - s_bytes); end
      checks++; if (last_byte !== 8'h12) begin errors++; $display("FAIL rstmid_byte: got %h expected 12", last_byte); end
      checks++; if (n_frame - s_frame !== 0) begin errors++; $display("FAIL rstmid_frame: got %0d expected 0", n_frame - s_frame); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      snap(); rx_ready = 1'b1;
      send_frame(8'h07, 1'b1, 1'b1, 1'b0);
      wait_clks(100);
      checks++; if (n_parity - s_parity !== 1) begin errors++; $display("FAIL par_pulse: got %0d expected 1", n_parity - s_parity); end
      checks++; if (n_bytes - s_bytes !== 0) begin errors++; $display("FAIL par_dropped: got %0d expected 0", n_bytes - s_bytes); end
      checks++; if (n_frame - s_frame !== 0) begin errors++; $display("FAIL par_frame: got %0d expected 0", n_frame - s_frame); end
      snap();
      send_frame(8'h07, 1'b1, 1'b1, 1'b1);
      wait_clks(100);
      checks++; if (n_bytes - s_bytes !== 1) begin errors++; $display("FAIL par_ok_count: got %0d expected 1", n_bytes - s_bytes); end
      checks++; if (last_byte !== 8'h07) begin errors++; $display("FAIL par_ok_data: got %h expected 07", last_byte); end
      checks++; if (n_parity - s_parity !== 0) begin errors++; $display("FAIL par_ok_pulse: got %0d expected 0", n_parity - s_parity); end
   endtask
`endif

   initial begin
      test_reset();
      test_basic();
      test_back_to_back();
      test_frame_err();
      test_glitch();
      test_reset_mid();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
